// File: rtl/mux4_rr_arbiter_if.sv
// mux4_rr_arbiter_if: four-requester word bus into the arbiter plus its registered valid/ready output.
interface mux4_rr_arbiter_if #(parameter int n = 32);
    logic [3:0]   req;
    logic [n-1:0] D0, D1, D2, D3;
    logic         out_ready;
    logic [3:0]   gnt;
    logic [1:0]   sel;
    logic [n-1:0] out;
    logic         out_valid;
    modport master (output req, D0, D1, D2, D3, out_ready, input gnt, sel, out, out_valid);
    modport slave  (input req, D0, D1, D2, D3, out_ready, output gnt, sel, out, out_valid);
endinterface

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin share of one 4:1 mux tree among four requesters,
// registering the winning word and presenting it over valid/ready.
module mux4_rr_arbiter #(parameter int n = 32) (
    input logic clk,
    input logic rst,
    mux4_rr_arbiter_if.slave bus
);
    typedef enum logic {IDLE, HOLD} state_t;
    state_t       state, next_state;
    logic [1:0]   ptr, w, c;
    logic         can_load, load;
    logic [n-1:0] lo, hi, mux;
    // scan from lowest priority to highest so the first candidate after ptr wins
    always_comb begin
        w = ptr;
        c = ptr;
        for (int k = 3; k >= 0; k--) begin
            c = ptr + 2'(k);
            w = bus.req[c] ? c : w;
        end
    end
    assign can_load = (state == IDLE) || bus.out_ready;
    assign load     = can_load && (|bus.req) && !rst;
    assign lo  = w[0] ? bus.D1 : bus.D0;
    assign hi  = w[0] ? bus.D3 : bus.D2;
    assign mux = w[1] ? hi : lo;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= next_state;
    always_comb
        next_state = load ? HOLD : (state == HOLD && bus.out_ready) ? IDLE : state;
    always_comb begin
        bus.gnt       = load ? 4'b0001 << w : 4'b0000;
        bus.out_valid = state == HOLD;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            bus.out <= '0;
            bus.sel <= '0;
            ptr     <= '0;
        end else if (load) begin
            bus.out <= mux;
            bus.sel <= w;
            ptr     <= w + 2'd1;
        end
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: directed and random stimulus against a queue-based round-robin model.
module tb_mux4_rr_arbiter;
    localparam int N = 32;
    logic clk = 0, rst = 1;
    int checks = 0, errors = 0;
    mux4_rr_arbiter_if #(N) bus ();
    mux4_rr_arbiter #(.n(N)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    logic [N-1:0]   dv [4];
    logic [N+1:0]   sb [$];
    int             mptr = 0;
    bit             mvalid = 0;
    logic [3:0]     lastg = 0;

    function automatic int winner(logic [3:0] r, int p);
        for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    task automatic chk(string name, logic [N-1:0] act, logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard monitor: each consumed word must match the oldest expected grant
    always @(negedge clk)
        if (!rst && bus.out_valid && bus.out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL consume: unexpected word %h sel %0d at %0t", bus.out, bus.sel, $time);
            end else begin
                logic [N+1:0] e;
                e = sb.pop_front();
                if ({bus.sel, bus.out} !== e) begin
                    errors++;
                    $display("FAIL consume: got sel %0d out %h expected sel %0d out %h at %0t",
                             bus.sel, bus.out, e[N+1:N], e[N-1:0], $time);
                end
            end
        end

    task automatic step(input logic [3:0] r, input logic rd);
        int w;
        logic [3:0] eg;
        bus.req = r; bus.out_ready = rd;
        bus.D0 = dv[0]; bus.D1 = dv[1]; bus.D2 = dv[2]; bus.D3 = dv[3];
        @(negedge clk);
        w  = winner(r, mptr);
        eg = ((!mvalid || rd) && w >= 0) ? 4'(1 << w) : 4'b0;
        chk("gnt", 32'(bus.gnt), 32'(eg));
        chk("out_valid", 32'(bus.out_valid), 32'(mvalid));
        lastg = eg;
        if (eg != 0) begin
            sb.push_back({2'(w), dv[w]});
            mptr = (w + 1) % 4;
            mvalid = 1;
        end else if (mvalid && rd) mvalid = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_now(input logic [3:0] r);
        #1 rst = 1;
        bus.req = r;
        #1;
        chk("rst_out", bus.out, '0);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_sel", 32'(bus.sel), 0);
        chk("rst_gnt", 32'(bus.gnt), 0);
        sb.delete();
        mptr = 0; mvalid = 0; lastg = 0;
        @(posedge clk);
        #1 rst = 0;
    endtask

    initial begin
        logic [3:0] r;
        bus.req = 0; bus.out_ready = 0;
        for (int i = 0; i < 4; i++) dv[i] = 0;
        bus.D0 = 0; bus.D1 = 0; bus.D2 = 0; bus.D3 = 0;
        #1 reset_now(4'b0000);
        dv[1] = 32'h12345678;
        step(4'b0010, 0);
        repeat (3) step(4'b0000, 0);
        chk("single_out", bus.out, 32'h12345678);
        chk("single_sel", 32'(bus.sel), 1);
        step(4'b0000, 1);
        step(4'b0000, 1);
        dv[3] = 32'h33; dv[0] = 32'h00;
        step(4'b1001, 1);
        dv[3] = 32'h333;
        step(4'b1001, 1);
        dv[0] = 32'h1000;
        step(4'b1000, 1);
        step(4'b0001, 1);
        chk("wrap_sel", 32'(bus.sel), 0);
        dv[1] = 32'h111; dv[2] = 32'h222;
        repeat (5) step(4'b0110, 0);
        step(4'b0110, 1);
        step(4'b0000, 1);
        for (int i = 0; i < 4; i++) dv[i] = 32'hA0 + i;
        reset_now(4'b0000);
        repeat (5) step(4'b1111, 1);
        step(4'b0000, 1);
        dv[2] = 32'hDEADBEEF;
        step(4'b0100, 0);
        chk("hold_word", bus.out, 32'hDEADBEEF);
        dv[2] = 32'h0BADF00D;
        reset_now(4'b0100);
        step(4'b0100, 1);
        chk("post_rst_out", bus.out, 32'h0BADF00D);
        r = 4'b0;
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < 4; i++)
                if (lastg[i] || !r[i]) begin
                    r[i] = 1'($urandom_range(0, 1));
                    dv[i] = $urandom;
                end else if ($urandom_range(0, 7) == 0) r[i] = 0;
            step(r, $urandom_range(0, 3) != 0);
        end
        repeat (2) step(4'b0000, 1);
        chk("sb_empty", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

- Shares one 4:1 n-bit mux datapath (three 2:1 mux cells in a tree) among four requesters with round-robin fairness.
- Sequences the mux select, registers the winning word, and presents it downstream over a valid/ready handshake.
- Sits between four independent producers and one shared consumer bus.

## Interface
Parameters:
- n, 32, data width of each requester word and of the output.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request vector; bit i = requester i has a word on Di.
- D0, D1, D2, D3  input  n each  requester data words.
- out_ready  input  1  consumer accepts out this cycle.
- gnt  output  4  one-hot grant, combinational; bit i high = Di is captured at this edge.
- sel  output  2  registered index of the requester whose word is held in out.
- out  output  n  registered data word.
- out_valid  output  1  out holds an unconsumed word.

## Operation
- States:
  - IDLE: out_valid=0.
  - HOLD: out_valid=1.
- Internal round-robin pointer ptr[1:0] = highest-priority requester.
- Candidate search order: ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- Winner w = first candidate with req[w]=1.
- can_load = (state==IDLE) || (state==HOLD && out_ready).
- gnt:
  - gnt[w]=1 when can_load && |req; all other bits 0.
  - gnt=0 otherwise, including while rst is high.
- On an edge where gnt is nonzero:
  - out <= Dw, through the mux tree driven by w.
  - sel <= w.
  - ptr <= w+1 mod 4.
  - state <= HOLD.
- On an edge where state==HOLD, out_ready=1 and req=0:
  - state <= IDLE.
  - out, sel and ptr hold their values.
- On an edge where state==HOLD and out_ready=0: nothing changes, and req is ignored.
- Requester contract: hold req[i] and Di stable until it samples gnt[i]=1 at an edge.
- A requester may keep req[i] high to queue its next word; it must update Di in the cycle after its grant.
- Arithmetic: pointer increment wraps 3->0; no other arithmetic.

## Timing
- Reset values, forced asynchronously on rst rising and held while rst=1:
  - state=IDLE, ptr=0, out=0, sel=0, out_valid=0, gnt=0.
- Reset mid-HOLD discards the held word; no grant is issued until the first edge after rst falls.
- Latency: req seen in IDLE -> out_valid=1 and out=Dw one cycle later.
- Throughput: one word per cycle when out_ready stays high and requests are continuous (HOLD->HOLD reload).
- Simultaneous consume and load in HOLD: the old word is accepted by the consumer and the new word replaces it at the same edge. out_valid stays 1 with no bubble.
- out_ready=1 in IDLE has no effect.
- req dropping while waiting (never granted) is legal; that requester is simply skipped.
- Fairness: with all four requesting continuously, every requester is granted once in any 4 consecutive grants.

## Test plan
- Reset:
  - Stimulus: assert rst mid-HOLD with out=0xDEADBEEF.
  - Response: out=0, out_valid=0, sel=0, gnt=0 immediately, without waiting for a clock edge.
  - After release with req=4'b0100: gnt=4'b0100 and out=D2 next edge.
- Single request:
  - Stimulus: req=4'b0010, D1=0x12345678, out_ready=0.
  - Response: gnt[1]=1 for one cycle; out=0x12345678, sel=1, out_valid=1.
  - While out_ready=0: gnt=0 and out stays stable.
  - After out_ready=1 with no new req: IDLE next edge.
- Round-robin:
  - Stimulus: req=4'b1111 held with out_ready=1 and Di=i+0xA0.
  - Response: successive out values are 0xA0, 0xA1, 0xA2, 0xA3, 0xA0; one per cycle, out_valid continuously 1.
- Pointer skip:
  - Stimulus: after a grant to requester 1, apply req=4'b1001.
  - Response: grant to 3 (not 0); ptr=0; the next grant with req=4'b1001 goes to 0.
- Backpressure with competing requests:
  - Stimulus: HOLD with out_ready=0 for 5 cycles while req=4'b0110.
  - Response: no grants and out unchanged during those cycles.
  - On the first out_ready=1 edge: the word is replaced by the round-robin winner.
- Wrap:
  - Stimulus: grant requester 3, then req=4'b0001.
  - Response: ptr wraps to 0, grant to 0, sel=0.
